// File: rtl/router_packet_arbiter_if.sv
// Handshake bundle between the requesters, the packet arbiter and the output port.
// The arbiter takes the slave view; whatever drives requesters and the port takes the master view.
interface router_packet_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int N     = 3,
    parameter int CNT_W = 16
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_last;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic               out_last;
    logic [WIDTH-1:0]   out_data;
    logic               out_ready;
    logic [IDW-1:0]     grant_id;
    logic               locked;
    logic [N*CNT_W-1:0] pkt_cnt;

    modport master (
        output in_valid, in_last, in_data, out_ready,
        input  in_ready, out_valid, out_last, out_data, grant_id, locked, pkt_cnt
    );

    modport slave (
        input  in_valid, in_last, in_data, out_ready,
        output in_ready, out_valid, out_last, out_data, grant_id, locked, pkt_cnt
    );
endinterface

// File: rtl/router_packet_arbiter.sv
// Round-robin packet arbiter for one router output port: holds the grant for a whole
// packet, registers the selected flit and keeps saturating per-requester packet counts.
module router_packet_arbiter #(
    parameter int WIDTH = 32,
    parameter int N     = 3,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    router_packet_arbiter_if.slave bus
);
    localparam int IDW = $clog2(N);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] cnt_q [N];

    logic [IDW-1:0]   winner_s;
    logic             found_s;
    logic [IDW-1:0]   sel_s;
    logic             space_s;
    logic             accept_s;
    logic             inc_s;
    logic [N-1:0]     in_ready_s;

    assign space_s = !out_valid_q || bus.out_ready;

    // Round-robin search: the earliest valid requester at or after ptr wins.
    always_comb begin
        logic [IDW:0]   raw;
        logic [IDW-1:0] idx;
        found_s  = 1'b0;
        winner_s = '0;
        raw      = '0;
        idx      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            raw      = {1'b0, ptr_q} + (IDW + 1)'(k);
            idx      = (raw >= (IDW + 1)'(N)) ? IDW'(raw - (IDW + 1)'(N)) : IDW'(raw);
            winner_s = bus.in_valid[idx] ? idx : winner_s;
            found_s  = found_s | bus.in_valid[idx];
        end
    end

    // Grant, handshake and next-state decode for the packet FSM and output register.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        in_ready_s  = '0;
        accept_s    = 1'b0;
        inc_s       = 1'b0;

        case (state_q)
            S_IDLE:   sel_s = winner_s;
            S_LOCKED: sel_s = grant_q;
            default:  sel_s = winner_s;
        endcase

        // A locked grant keeps the slot reserved even across a valid gap.
        if (!rst && space_s && (found_s || (state_q == S_LOCKED))) begin
            in_ready_s[sel_s] = 1'b1;
        end else begin
            in_ready_s = '0;
        end

        accept_s = in_ready_s[sel_s] & bus.in_valid[sel_s];

        if (accept_s) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in_data[int'(sel_s) * WIDTH +: WIDTH];
            out_last_d  = bus.in_last[sel_s];
            grant_d     = sel_s;
            if (bus.in_last[sel_s]) begin
                state_d = S_IDLE;
                ptr_d   = (sel_s == IDW'(N - 1)) ? '0 : sel_s + IDW'(1);
                inc_s   = 1'b1;
            end else begin
                state_d = S_LOCKED;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // FSM, round-robin pointer and output register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    // Saturating completed-packet counters, one per requester.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                cnt_q[i] <= '0;
            end else if (inc_s && (sel_s == IDW'(i)) && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end else begin
                cnt_q[i] <= cnt_q[i];
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_cnt_out
        assign bus.pkt_cnt[gi * CNT_W +: CNT_W] = cnt_q[gi];
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;
    assign bus.grant_id  = grant_q;
    assign bus.locked    = (state_q == S_LOCKED);
endmodule

// File: tb/tb_router_packet_arbiter.sv
// Randomised and directed bench for router_packet_arbiter against a packet-level reference model;
// a second instance with 4-bit counters exercises counter saturation on the same stimulus.
module tb_router_packet_arbiter;
    localparam int WIDTH = 32;
    localparam int N     = 3;
    localparam int CNT_W = 16;
    localparam int SCW   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    router_packet_arbiter_if #(.WIDTH(WIDTH), .N(N), .CNT_W(CNT_W)) bus ();
    router_packet_arbiter_if #(.WIDTH(WIDTH), .N(N), .CNT_W(SCW))   sbus ();

    router_packet_arbiter #(.WIDTH(WIDTH), .N(N), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    router_packet_arbiter #(.WIDTH(WIDTH), .N(N), .CNT_W(SCW)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    assign sbus.in_valid  = bus.in_valid;
    assign sbus.in_last   = bus.in_last;
    assign sbus.in_data   = bus.in_data;
    assign sbus.out_ready = bus.out_ready;

    int total = 0;
    int bad   = 0;

    // reference model state
    int          m_owner;
    int          m_ptr;
    int          m_gid;
    int          m_cnt [N];
    logic        m_ov;
    logic        m_ol;
    logic [31:0] m_od;

    // requester generator state
    int          rem [N];
    logic [N-1:0] acc_mask;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_gid   = 0;
        m_ov    = 1'b0;
        m_ol    = 1'b0;
        m_od    = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // One clock: compare everything at the falling edge, advance the model, return just after the rising edge.
    task automatic cycle();
        int           tgt;
        logic         sp;
        logic         acc;
        logic [N-1:0] er;
        @(negedge clk);
        sp  = !m_ov || bus.out_ready;
        tgt = -1;
        if (m_owner >= 0) tgt = m_owner;
        else begin
            for (int k = 0; k < N; k++) begin
                if (tgt < 0 && bus.in_valid[(m_ptr + k) % N]) tgt = (m_ptr + k) % N;
            end
        end
        er = '0;
        if (!rst && sp && tgt >= 0) er[tgt] = 1'b1;

        check_val("in_ready", 64'(bus.in_ready), 64'(er));
        check_val("out_valid", 64'(bus.out_valid), 64'(m_ov));
        check_val("out_data", 64'(bus.out_data), 64'(m_od));
        check_val("out_last", 64'(bus.out_last), 64'(m_ol));
        check_val("locked", 64'(bus.locked), 64'(m_owner >= 0));
        check_val("grant_id", 64'(bus.grant_id), 64'(m_gid));
        for (int i = 0; i < N; i++) begin
            check_val("pkt_cnt", 64'(bus.pkt_cnt[i*CNT_W +: CNT_W]), 64'(sat(m_cnt[i], 65535)));
            check_val("pkt_cnt_sat", 64'(sbus.pkt_cnt[i*SCW +: SCW]), 64'(sat(m_cnt[i], 15)));
        end

        acc_mask = '0;
        if (rst) begin
            model_reset();
        end else begin
            acc = 1'b0;
            if (tgt >= 0) acc = er[tgt] && bus.in_valid[tgt];
            if (acc) begin
                acc_mask[tgt] = 1'b1;
                if (rem[tgt] > 0) rem[tgt]--;
                m_ov  = 1'b1;
                m_od  = bus.in_data[tgt*WIDTH +: WIDTH];
                m_ol  = bus.in_last[tgt];
                m_gid = tgt;
                if (bus.in_last[tgt]) begin
                    m_owner = -1;
                    m_ptr   = (tgt + 1) % N;
                    m_cnt[tgt]++;
                end else begin
                    m_owner = tgt;
                end
            end else if (bus.out_ready) begin
                m_ov = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Requesters hold a presented flit until accepted, then may present the next one.
    task automatic gen_inputs(input int pv, input logic [N-1:0] en, input int maxlen);
        for (int i = 0; i < N; i++) begin
            if (acc_mask[i]) bus.in_valid[i] = 1'b0;
            if (!bus.in_valid[i] && en[i] && ($urandom_range(99) < pv)) begin
                if (rem[i] == 0) rem[i] = $urandom_range(maxlen, 1);
                bus.in_valid[i] = 1'b1;
                bus.in_last[i]  = (rem[i] == 1);
                bus.in_data[i*WIDTH +: WIDTH] = $urandom;
            end
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.in_valid  = '0;
        bus.in_last   = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        cycle();
        rst = 1'b0;
        check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_locked", 64'(bus.locked), 64'd0);
        check_val("rst_grant", 64'(bus.grant_id), 64'd0);
        check_val("rst_out_data", 64'(bus.out_data), 64'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = '0;
        bus.in_last   = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        acc_mask      = '0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        model_reset();
        @(posedge clk);
        #1;

        // single-flit packet from requester 0
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 3'b001;
        bus.in_last   = 3'b001;
        bus.in_data[31:0] = 32'h0100_0009;
        cycle();
        bus.in_valid = '0;
        check_val("t1_data", 64'(bus.out_data), 64'h0100_0009);
        check_val("t1_cnt0", 64'(bus.pkt_cnt[CNT_W-1:0]), 64'd1);
        check_val("t1_locked", 64'(bus.locked), 64'd0);
        cycle();

        // all requesters busy with single-flit packets: strict rotation
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            gen_inputs(100, 3'b111, 1);
            cycle();
            check_val("t2_order", 64'(bus.grant_id), 64'(k % N));
        end
        for (int i = 0; i < N; i++)
            check_val("t2_cnt", 64'(bus.pkt_cnt[i*CNT_W +: CNT_W]), 64'd2);

        // three-flit packet from requester 1 stays contiguous
        do_reset();
        bus.out_ready = 1'b1;
        rem[1] = 3;
        gen_inputs(100, 3'b010, 1);
        cycle();
        check_val("t3_order", 64'(bus.grant_id), 64'd1);
        for (int k = 0; k < 4; k++) begin
            gen_inputs(100, (k < 2) ? 3'b111 : 3'b101, 1);
            cycle();
            check_val("t3_order", 64'(bus.grant_id), (k < 2) ? 64'd1 : ((k == 2) ? 64'd2 : 64'd0));
        end

        // downstream stall holds the registered flit
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 3'b001;
        bus.in_last   = 3'b001;
        bus.in_data[31:0] = 32'hA5A5_0004;
        cycle();
        bus.in_valid  = '0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            gen_inputs(100, 3'b110, 2);
            cycle();
            check_val("t4_hold", 64'(bus.out_data), 64'hA5A5_0004);
            check_val("t4_valid", 64'(bus.out_valid), 64'd1);
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            gen_inputs(100, 3'b110, 2);
            cycle();
        end

        // reset in the middle of a three-flit packet
        do_reset();
        bus.out_ready = 1'b1;
        rem[2] = 3;
        for (int k = 0; k < 2; k++) begin
            gen_inputs(100, 3'b100, 1);
            cycle();
        end
        check_val("t5_locked_pre", 64'(bus.locked), 64'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_val("t5_valid", 64'(bus.out_valid), 64'd0);
        check_val("t5_locked", 64'(bus.locked), 64'd0);
        check_val("t5_cnt", 64'(bus.pkt_cnt), 64'd0);
        acc_mask = 3'b000;
        gen_inputs(100, 3'b111, 1);
        cycle();
        check_val("t5_tie", 64'(bus.grant_id), 64'd0);

        // counter saturation on the narrow-counter instance
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            gen_inputs(100, 3'b001, 1);
            cycle();
        end
        check_val("t6_sat", 64'(sbus.pkt_cnt[SCW-1:0]), 64'd15);
        check_val("t6_wide", 64'(bus.pkt_cnt[CNT_W-1:0]), 64'd20);
        for (int k = 0; k < 3; k++) begin
            gen_inputs(100, 3'b001, 1);
            cycle();
        end
        check_val("t6_sat_hold", 64'(sbus.pkt_cnt[SCW-1:0]), 64'd15);

        // random traffic with valid gaps, stalls and occasional reset
        do_reset();
        for (int ph = 0; ph < 6; ph++) begin
            int pv;
            int pr;
            pv = 20 + ph * 15;
            pr = 40 + ((ph * 37) % 60);
            for (int k = 0; k < 300; k++) begin
                rst = ($urandom_range(299) == 0);
                gen_inputs(pv, 3'b111, 4);
                bus.out_ready = ($urandom_range(99) < pr);
                cycle();
            end
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
